// File: rtl/pmod_amp3_pkg.sv
// Shared constants and types for the Pmod AMP3 I2S transmitter.
// Sample fields are sized for the widest supported word and hold zero-extended samples.
package pmod_amp3_pkg;

  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  localparam int SLOT_W     = $clog2(SLOT_BITS);
  localparam int BIT_W      = $clog2(FRAME_BITS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [SLOT_BITS-2:0] left;
    logic [SLOT_BITS-2:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_clkgen.sv
// MCLK / SCLK generation and the per-frame bit counter.
// Outputs are registered from next-state values so they line up with the counters.
module i2s_clkgen
  import pmod_amp3_pkg::*;
#(
  parameter int MCLK_DIV = 2,
  parameter int SCLK_DIV = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic             lineout_mclk,
  output logic             lineout_sclk,
  output logic [BIT_W-1:0] bit_cnt,
  output logic             sclk_fall
);

  localparam int MW = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
  localparam int SW = $clog2(SCLK_DIV);

  logic [MW-1:0] mclk_cnt, mclk_nxt;
  logic [SW-1:0] div_cnt, div_nxt;

  // sclk_fall marks the edge on which div_cnt wraps and the bit counter advances
  assign sclk_fall = run && (div_cnt == SW'(SCLK_DIV - 1));

  always_comb begin
    mclk_nxt = (mclk_cnt == MW'(MCLK_DIV - 1)) ? '0 : mclk_cnt + 1'b1;
    div_nxt  = '0;
    if (run) div_nxt = sclk_fall ? '0 : div_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mclk_cnt     <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      lineout_mclk <= 1'b0;
      lineout_sclk <= 1'b0;
    end else begin
      mclk_cnt     <= mclk_nxt;
      lineout_mclk <= (mclk_nxt >= MW'(MCLK_DIV / 2));
      div_cnt      <= div_nxt;
      lineout_sclk <= (div_nxt >= SW'(SCLK_DIV / 2));
      if (!run)           bit_cnt <= '0;
      else if (sclk_fall) bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pmod_amp3_i2s_tx.sv
// Philips I2S serialiser for the Pmod AMP3: single-entry sample buffer, frame registers,
// run/idle sequencing and the serial data mux.
//   state | meaning
//   IDLE  | counters and SCLK/LRCK/SDOUT held at 0, MCLK still running
//   RUN   | framing active; loads a new frame on every 63->0 wrap while enabled
module pmod_amp3_i2s_tx
  import pmod_amp3_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter int MCLK_DIV = 2,
  parameter int SCLK_DIV = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] sample_left,
  input  logic [WIDTH-1:0] sample_right,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             lineout_mclk,
  output logic             lineout_sclk,
  output logic             lineout_lrck,
  output logic             lineout_sdout,
  output logic             frame_start,
  output logic             underrun
);

  state_t               state, state_nxt;
  logic                 running;
  logic [BIT_W-1:0]     bit_cnt, bit_nxt;
  logic                 sclk_fall, frame_wrap, load, accept;
  logic                 lrck_d, sdout_d;
  logic [SLOT_W-1:0]    pos, idx;
  logic [SLOT_BITS-2:0] chan;
  stereo_sample_t       pend, frame;

  assign running = (state == RUN);

  i2s_clkgen #(
    .MCLK_DIV (MCLK_DIV),
    .SCLK_DIV (SCLK_DIV)
  ) u_clkgen (
    .clk          (clk),
    .reset        (reset),
    .run          (running),
    .lineout_mclk (lineout_mclk),
    .lineout_sclk (lineout_sclk),
    .bit_cnt      (bit_cnt),
    .sclk_fall    (sclk_fall)
  );

  assign frame_wrap = sclk_fall && (bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign accept     = sample_valid && sample_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        // enable only matters at the frame boundary so a frame is never cut short
        if (frame_wrap) begin
          if (enable) load      = 1'b1;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line outputs are computed for the bit position that becomes current on this edge.
  always_comb begin
    bit_nxt = sclk_fall ? bit_cnt + 1'b1 : bit_cnt;
    pos     = bit_nxt[SLOT_W-1:0];
    idx     = SLOT_W'(WIDTH) - pos;
    chan    = bit_nxt[BIT_W-1] ? frame.right : frame.left;
    lrck_d  = 1'b0;
    sdout_d = 1'b0;
    if (state_nxt == RUN) begin
      lrck_d = bit_nxt[BIT_W-1];
      if (pos != '0 && pos <= SLOT_W'(WIDTH)) sdout_d = chan[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend          <= '0;
      frame         <= '0;
      sample_ready  <= 1'b1;
      frame_start   <= 1'b0;
      underrun      <= 1'b0;
      lineout_lrck  <= 1'b0;
      lineout_sdout <= 1'b0;
    end else begin
      frame_start   <= load;
      underrun      <= load && sample_ready;
      lineout_lrck  <= lrck_d;
      lineout_sdout <= sdout_d;
      // a load sees the buffer as it was before this edge; a same-cycle accept stays pending
      if (load) frame <= sample_ready ? '0 : pend;
      if (accept) begin
        pend.left    <= (SLOT_BITS - 1)'(sample_left);
        pend.right   <= (SLOT_BITS - 1)'(sample_right);
        sample_ready <= 1'b0;
      end else if (load) begin
        sample_ready <= 1'b1;
      end
    end
  end

endmodule
